// File: rtl/xc_mp_pkg.sv
// Shared encodings for the XCrypto multi-precision unit: op codes and sequencer states.
package xc_mp_pkg;

  typedef enum logic [1:0] {
    XC_MP_MADD3 = 2'd0,
    XC_MP_MSUB3 = 2'd1,
    XC_MP_MACC1 = 2'd2,
    XC_MP_MMUL3 = 2'd3
  } xc_mp_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } xc_mp_state_t;

endpackage

// File: rtl/xc_mp_mul_step.sv
// One step of the iterative multiplier: acc + (rs2 * slice) shifted into position.
module xc_mp_mul_step #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic [2*XLEN-1:0]         acc,
  input  logic [XLEN-1:0]           rs2,
  input  logic [MUL_BITS-1:0]       slice,
  input  logic [$clog2(XLEN)-1:0]   shamt,
  output logic [2*XLEN-1:0]         acc_nxt
);

  logic [2*XLEN-1:0] prod;

  assign prod    = {{XLEN{1'b0}}, rs2} * {{(2*XLEN-MUL_BITS){1'b0}}, slice};
  assign acc_nxt = acc + (prod << shamt);

endmodule

// File: rtl/xc_mp_arith_seq.sv
// Sequential multi-precision arithmetic unit (madd.3 / msub.3 / macc.1 / mmul.3).
//   state | meaning
//   IDLE  | waiting for an operation, in_ready high
//   MUL   | iterating the multiplier, one MUL_BITS slice of rs1 per cycle
//   DONE  | result held on res_*, out_valid high until consumed
module xc_mp_arith_seq #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1,
  parameter int HAS_MUL  = 1
) (
  input  logic            g_clk,
  input  logic            g_rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res_lo,
  output logic [XLEN-1:0] res_hi,
  output logic            res_err
);

  import xc_mp_pkg::*;

  localparam int STEPS = XLEN / MUL_BITS;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SHW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  xc_mp_state_t      state;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic [SHW-1:0]    shamt;

  xc_mp_op_t         op_in;
  logic              accept;
  logic              mul_sel;
  logic [XLEN:0]     sum_w;
  logic [XLEN:0]     diff_w;
  logic [2*XLEN-1:0] macc_w;
  logic [XLEN-1:0]   add_lo;
  logic [XLEN-1:0]   add_hi;
  logic              add_err;

  assign op_in    = xc_mp_op_t'(in_op);
  assign in_ready = !g_rst && !flush && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign mul_sel  = (op_in == XC_MP_MMUL3) && (HAS_MUL != 0);

  // Top bit of the widened difference is the borrow out.
  assign sum_w  = {1'b0, in_rs1} + {1'b0, in_rs2} + {{XLEN{1'b0}}, in_rs3[0]};
  assign diff_w = {1'b0, in_rs1} - {1'b0, in_rs2} - {{XLEN{1'b0}}, in_rs3[0]};
  assign macc_w = {in_rs2, in_rs1} + {{XLEN{1'b0}}, in_rs3};

  always_comb begin
    add_lo  = '0;
    add_hi  = '0;
    add_err = 1'b0;
    case (op_in)
      XC_MP_MADD3: begin
        add_lo = sum_w[XLEN-1:0];
        add_hi = {{(XLEN-1){1'b0}}, sum_w[XLEN]};
      end
      XC_MP_MSUB3: begin
        add_lo = diff_w[XLEN-1:0];
        add_hi = {{(XLEN-1){1'b0}}, diff_w[XLEN]};
      end
      XC_MP_MACC1: begin
        add_lo = macc_w[XLEN-1:0];
        add_hi = macc_w[2*XLEN-1:XLEN];
      end
      default: add_err = 1'b1;
    endcase
  end

  assign shamt = SHW'(int'(count) * MUL_BITS);

  xc_mp_mul_step #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_mul_step (
    .acc     (acc),
    .rs2     (mul_b),
    .slice   (mul_a[MUL_BITS-1:0]),
    .shamt   (shamt),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      res_lo    <= '0;
      res_hi    <= '0;
      res_err   <= 1'b0;
      count     <= '0;
      acc       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (mul_sel) begin
        acc       <= {{XLEN{1'b0}}, in_rs3};
        mul_a     <= in_rs1;
        mul_b     <= in_rs2;
        count     <= '0;
        out_valid <= 1'b0;
        state     <= MUL;
      end else begin
        res_lo    <= add_lo;
        res_hi    <= add_hi;
        res_err   <= add_err;
        out_valid <= 1'b1;
        state     <= DONE;
      end
    end else begin
      case (state)
        MUL: begin
          acc   <= acc_nxt;
          mul_a <= mul_a >> MUL_BITS;
          count <= count + CW'(1);
          if (count == LAST) begin
            res_lo    <= acc_nxt[XLEN-1:0];
            res_hi    <= acc_nxt[2*XLEN-1:XLEN];
            res_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
